// File: rtl/rv32_pkg.sv
// ----------------------------------------------------------------------------
// rv32_pkg
// Shared RV32IM decode constants for the ID/EX stage:
//   - base opcode values for every instruction class the stage understands
//   - 5-bit ALU opcodes, laid out as {funct3, funct7[5]/imm[10], funct7[0]}
//   - bit positions of the instruction fields
//   - operand-select encoding and small decode helper functions
// ----------------------------------------------------------------------------
package rv32_pkg;

   // Base opcodes (instr[6:0])
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   // ALU opcodes
   localparam logic [4:0] ALU_ADD    = 5'b00000;
   localparam logic [4:0] ALU_SUB    = 5'b00010;
   localparam logic [4:0] ALU_SLL    = 5'b00100;
   localparam logic [4:0] ALU_SLT    = 5'b01000;
   localparam logic [4:0] ALU_SLTU   = 5'b01100;
   localparam logic [4:0] ALU_XOR    = 5'b10000;
   localparam logic [4:0] ALU_SRL    = 5'b10100;
   localparam logic [4:0] ALU_SRA    = 5'b10110;
   localparam logic [4:0] ALU_OR     = 5'b11000;
   localparam logic [4:0] ALU_AND    = 5'b11100;
   localparam logic [4:0] ALU_MUL    = 5'b00001;
   localparam logic [4:0] ALU_MULH   = 5'b00101;
   localparam logic [4:0] ALU_MULHSU = 5'b01001;
   localparam logic [4:0] ALU_MULHU  = 5'b01101;
   localparam logic [4:0] ALU_DIV    = 5'b10001;
   localparam logic [4:0] ALU_DIVU   = 5'b10101;
   localparam logic [4:0] ALU_REM    = 5'b11001;
   localparam logic [4:0] ALU_REMU   = 5'b11101;

   // Instruction field positions (LSB of each field)
   localparam int unsigned OPC_LSB   = 0;
   localparam int unsigned RD_LSB    = 7;
   localparam int unsigned F3_LSB    = 12;
   localparam int unsigned RS1_LSB   = 15;
   localparam int unsigned RS2_LSB   = 20;
   localparam int unsigned F7_0_BIT  = 25;
   localparam int unsigned F7_5_BIT  = 30;

   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SRX = 3'b101;

   // Operand-select classes, decoded once at capture time
   typedef enum logic [2:0] {
      SEL_NONE     = 3'd0,  // unknown opcode: both operands 0
      SEL_RS_RS    = 3'd1,  // OP, BRANCH
      SEL_RS_IMM   = 3'd2,  // OP-IMM, LOAD, STORE
      SEL_RS_SHAMT = 3'd3,  // OP-IMM shifts: only imm[4:0] is the amount
      SEL_ZERO_IMM = 3'd4,  // LUI
      SEL_PC_IMM   = 3'd5,  // AUIPC
      SEL_PC_LINK  = 3'd6   // JAL, JALR
   } opsel_e;

   function automatic logic uses_rs1(input logic [6:0] opc);
      case (opc)
         OPC_OP, OPC_OP_IMM, OPC_LOAD,
         OPC_STORE, OPC_BRANCH, OPC_JALR: return 1'b1;
         default:                         return 1'b0;
      endcase
   endfunction

   function automatic logic uses_rs2(input logic [6:0] opc);
      case (opc)
         OPC_OP, OPC_STORE, OPC_BRANCH: return 1'b1;
         default:                       return 1'b0;
      endcase
   endfunction

   function automatic logic writes_rd(input logic [6:0] opc);
      case (opc)
         OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI,
         OPC_AUIPC, OPC_JAL, OPC_JALR: return 1'b1;
         default:                      return 1'b0;
      endcase
   endfunction

   function automatic opsel_e decode_opsel(input logic [6:0] opc, input logic [2:0] f3);
      case (opc)
         OPC_OP, OPC_BRANCH:  return SEL_RS_RS;
         OPC_OP_IMM:          return ((f3 == F3_SLL) || (f3 == F3_SRX)) ? SEL_RS_SHAMT : SEL_RS_IMM;
         OPC_LOAD, OPC_STORE: return SEL_RS_IMM;
         OPC_LUI:             return SEL_ZERO_IMM;
         OPC_AUIPC:           return SEL_PC_IMM;
         OPC_JAL, OPC_JALR:   return SEL_PC_LINK;
         default:             return SEL_NONE;
      endcase
   endfunction

   // {funct3, b1, b0}; imm[10] of an I-type equals instr[30], but the
   // decoder's immediate is the authoritative source for OP-IMM.
   function automatic logic [4:0] decode_alu_op(input logic [31:0] instr, input logic imm_b10);
      logic [2:0] f3;
      f3 = instr[F3_LSB +: 3];
      case (instr[OPC_LSB +: 7])
         OPC_OP:     return {f3, instr[F7_5_BIT], instr[F7_0_BIT]};
         OPC_OP_IMM: return {f3, (f3 == F3_SRX) ? imm_b10 : 1'b0, 1'b0};
         OPC_BRANCH: return ALU_SUB;
         default:    return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/ex_forward_mux.sv
// ----------------------------------------------------------------------------
// ex_forward_mux
// Picks the freshest value of one source register for the EX stage.
//   rs_i / rf_data_i       : register index and value captured from the file
//   exmem_* / memwb_*      : in-flight results from MEM and WB
//   data_o                 : forwarded operand
// EX/MEM wins over MEM/WB since it is the younger producer.
// ----------------------------------------------------------------------------
module ex_forward_mux #(
   parameter int unsigned XLEN = 32
) (
   input  logic [4:0]      rs_i,
   input  logic [XLEN-1:0] rf_data_i,
   input  logic [4:0]      exmem_rd_i,
   input  logic            exmem_regwrite_i,
   input  logic [XLEN-1:0] exmem_result_i,
   input  logic [4:0]      memwb_rd_i,
   input  logic            memwb_regwrite_i,
   input  logic [XLEN-1:0] memwb_data_i,
   output logic [XLEN-1:0] data_o
);

   logic exmem_hit_s;
   logic memwb_hit_s;

   assign exmem_hit_s = exmem_regwrite_i && (exmem_rd_i != 5'd0) && (exmem_rd_i == rs_i);
   assign memwb_hit_s = memwb_regwrite_i && (memwb_rd_i != 5'd0) && (memwb_rd_i == rs_i);

   // Priority select of the forwarding source
   always_comb begin
      data_o = rf_data_i;
      if (exmem_hit_s) begin
         data_o = exmem_result_i;
      end else if (memwb_hit_s) begin
         data_o = memwb_data_i;
      end else begin
         data_o = rf_data_i;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register of the RV32IM core with forwarding, operand select,
// ALU opcode generation and load-use bubble insertion.
//   clk_i, rst_i (sync, active-high), stall_i (freeze), flush_i (kill)
//   id_*      : decoded instruction and register-file reads from ID
//   exmem_*   : MEM-stage producer,  memwb_* : WB-stage producer
//   alu1_o, alu2_o, alu_op_o : ALU operands and opcode
//   ex_*      : registered EX-stage control/state
//   load_use_stall_o : hold PC and IF/ID for one cycle
// ----------------------------------------------------------------------------
module id_ex_stage
   import rv32_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned LINK_OFFSET = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            stall_i,
   input  logic            flush_i,
   input  logic            id_valid_i,
   input  logic [XLEN-1:0] id_pc_i,
   input  logic [31:0]     id_instr_i,
   input  logic [XLEN-1:0] id_rs1_data_i,
   input  logic [XLEN-1:0] id_rs2_data_i,
   input  logic [XLEN-1:0] id_imm_i,
   input  logic [4:0]      exmem_rd_i,
   input  logic            exmem_regwrite_i,
   input  logic [XLEN-1:0] exmem_result_i,
   input  logic [4:0]      memwb_rd_i,
   input  logic            memwb_regwrite_i,
   input  logic [XLEN-1:0] memwb_data_i,
   output logic [XLEN-1:0] alu1_o,
   output logic [XLEN-1:0] alu2_o,
   output logic [4:0]      alu_op_o,
   output logic            ex_valid_o,
   output logic [XLEN-1:0] ex_pc_o,
   output logic [4:0]      ex_rd_o,
   output logic            ex_regwrite_o,
   output logic            ex_mem_read_o,
   output logic            ex_mem_write_o,
   output logic [XLEN-1:0] ex_store_data_o,
   output logic            load_use_stall_o
);

   // ID-side field extraction
   logic [6:0] id_opc_s;
   logic [4:0] id_rd_s;
   logic [4:0] id_rs1_s;
   logic [4:0] id_rs2_s;
   logic       load_use_s;

   assign id_opc_s = id_instr_i[OPC_LSB +: 7];
   assign id_rd_s  = id_instr_i[RD_LSB  +: 5];
   assign id_rs1_s = id_instr_i[RS1_LSB +: 5];
   assign id_rs2_s = id_instr_i[RS2_LSB +: 5];

   // Stored EX-stage state
   logic            valid_r;
   logic [XLEN-1:0] pc_r;
   logic [4:0]      rd_r;
   logic [4:0]      rs1_r;
   logic [4:0]      rs2_r;
   logic [XLEN-1:0] rs1_data_r;
   logic [XLEN-1:0] rs2_data_r;
   logic [XLEN-1:0] imm_r;
   opsel_e          opsel_r;
   logic [4:0]      alu_op_r;
   logic            regwrite_r;
   logic            mem_read_r;
   logic            mem_write_r;

   // Load-use hazard: a LOAD in EX feeding a source used by the ID instruction
   always_comb begin
      load_use_s = 1'b0;
      if (valid_r && mem_read_r && (rd_r != 5'd0) && id_valid_i) begin
         load_use_s = (uses_rs1(id_opc_s) && (rd_r == id_rs1_s)) ||
                      (uses_rs2(id_opc_s) && (rd_r == id_rs2_s));
      end else begin
         load_use_s = 1'b0;
      end
   end

   // Pipeline register: reset > stall > flush/bubble > capture
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_r     <= 1'b0;
         pc_r        <= {XLEN{1'b0}};
         rd_r        <= 5'd0;
         rs1_r       <= 5'd0;
         rs2_r       <= 5'd0;
         rs1_data_r  <= {XLEN{1'b0}};
         rs2_data_r  <= {XLEN{1'b0}};
         imm_r       <= {XLEN{1'b0}};
         opsel_r     <= SEL_NONE;
         alu_op_r    <= 5'd0;
         regwrite_r  <= 1'b0;
         mem_read_r  <= 1'b0;
         mem_write_r <= 1'b0;
      end else if (stall_i) begin
         // Freeze: flush_i is held by the branch unit until the stall drops.
         valid_r     <= valid_r;
      end else if (flush_i || load_use_s) begin
         // Bubble: only the state that has side effects is killed.
         valid_r     <= 1'b0;
         regwrite_r  <= 1'b0;
         mem_read_r  <= 1'b0;
         mem_write_r <= 1'b0;
      end else begin
         valid_r     <= id_valid_i;
         pc_r        <= id_pc_i;
         rd_r        <= id_rd_s;
         rs1_r       <= id_rs1_s;
         rs2_r       <= id_rs2_s;
         rs1_data_r  <= id_rs1_data_i;
         rs2_data_r  <= id_rs2_data_i;
         imm_r       <= id_imm_i;
         opsel_r     <= decode_opsel(id_opc_s, id_instr_i[F3_LSB +: 3]);
         alu_op_r    <= decode_alu_op(id_instr_i, id_imm_i[10]);
         // Writes to x0 are dropped here so forwarding never matches them.
         regwrite_r  <= id_valid_i && writes_rd(id_opc_s) && (id_rd_s != 5'd0);
         mem_read_r  <= id_valid_i && (id_opc_s == OPC_LOAD);
         mem_write_r <= id_valid_i && (id_opc_s == OPC_STORE);
      end
   end

   // Forwarding for both sources
   logic [XLEN-1:0] fwd1_s;
   logic [XLEN-1:0] fwd2_s;

   ex_forward_mux #(.XLEN(XLEN)) u_fwd_rs1 (
      .rs_i             (rs1_r),
      .rf_data_i        (rs1_data_r),
      .exmem_rd_i       (exmem_rd_i),
      .exmem_regwrite_i (exmem_regwrite_i),
      .exmem_result_i   (exmem_result_i),
      .memwb_rd_i       (memwb_rd_i),
      .memwb_regwrite_i (memwb_regwrite_i),
      .memwb_data_i     (memwb_data_i),
      .data_o           (fwd1_s)
   );

   ex_forward_mux #(.XLEN(XLEN)) u_fwd_rs2 (
      .rs_i             (rs2_r),
      .rf_data_i        (rs2_data_r),
      .exmem_rd_i       (exmem_rd_i),
      .exmem_regwrite_i (exmem_regwrite_i),
      .exmem_result_i   (exmem_result_i),
      .memwb_rd_i       (memwb_rd_i),
      .memwb_regwrite_i (memwb_regwrite_i),
      .memwb_data_i     (memwb_data_i),
      .data_o           (fwd2_s)
   );

   // ALU operand select by instruction class
   always_comb begin
      alu1_o = {XLEN{1'b0}};
      alu2_o = {XLEN{1'b0}};
      case (opsel_r)
         SEL_RS_RS: begin
            alu1_o = fwd1_s;
            alu2_o = fwd2_s;
         end
         SEL_RS_IMM: begin
            alu1_o = fwd1_s;
            alu2_o = imm_r;
         end
         SEL_RS_SHAMT: begin
            // imm[10] carries the SRA/SRL selector; the ALU sees only shamt.
            alu1_o = fwd1_s;
            alu2_o = {{(XLEN-5){1'b0}}, imm_r[4:0]};
         end
         SEL_ZERO_IMM: begin
            alu1_o = {XLEN{1'b0}};
            alu2_o = imm_r;
         end
         SEL_PC_IMM: begin
            alu1_o = pc_r;
            alu2_o = imm_r;
         end
         SEL_PC_LINK: begin
            alu1_o = pc_r;
            alu2_o = XLEN'(LINK_OFFSET);
         end
         default: begin
            alu1_o = {XLEN{1'b0}};
            alu2_o = {XLEN{1'b0}};
         end
      endcase
   end

   assign alu_op_o         = alu_op_r;
   assign ex_valid_o       = valid_r;
   assign ex_pc_o          = pc_r;
   assign ex_rd_o          = rd_r;
   assign ex_regwrite_o    = regwrite_r;
   assign ex_mem_read_o    = mem_read_r;
   assign ex_mem_write_o   = mem_write_r;
   assign ex_store_data_o  = fwd2_s;
   assign load_use_stall_o = load_use_s;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the RV32IM five-stage core, sitting directly upstream of the execute ALU.
- Captures the decoded instruction from ID.
- Resolves EX/MEM and MEM/WB forwarding.
- Selects the two ALU operands and generates the 5-bit ALU opcode.
- Detects load-use hazards, inserts bubbles, and honours downstream stall and branch flush.

Parameters:
- XLEN, 32, datapath width.
- LINK_OFFSET, 4, constant placed on alu2 for JAL/JALR link computation.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock; reset is synchronous and active-high.
- stall_i  in  1  downstream freeze (memory wait).
- flush_i  in  1  branch/jump redirect; kill ID/EX contents.
- id_valid_i  in  1  ID holds a real instruction.
- id_pc_i  in  32  PC of the ID instruction.
- id_instr_i  in  32  raw instruction word.
- id_rs1_data_i  in  32  register-file read, rs1.
- id_rs2_data_i  in  32  register-file read, rs2.
- id_imm_i  in  32  sign-extended immediate from the decoder.
- exmem_rd_i  in  5  destination register in MEM.
- exmem_regwrite_i  in  1  MEM instruction writes rd.
- exmem_result_i  in  32  ALU result in MEM.
- memwb_rd_i  in  5  destination register in WB.
- memwb_regwrite_i  in  1  WB instruction writes rd.
- memwb_data_i  in  32  write-back data.
- alu1_o  out  32  ALU operand 1.
- alu2_o  out  32  ALU operand 2.
- alu_op_o  out  5  ALU opcode.
- ex_valid_o  out  1  EX holds a real instruction.
- ex_pc_o  out  32  PC in EX.
- ex_rd_o  out  5  destination register in EX.
- ex_regwrite_o  out  1  EX instruction writes rd (forced 0 when rd=0).
- ex_mem_read_o  out  1  EX instruction is a LOAD.
- ex_mem_write_o  out  1  EX instruction is a STORE.
- ex_store_data_o  out  32  forwarded rs2 for stores.
- load_use_stall_o  out  1  request to hold PC and IF/ID.

Behaviour:
- Reset:
  - ex_valid_o, ex_regwrite_o, ex_mem_read_o, ex_mem_write_o = 0.
  - ex_pc_o and ex_rd_o = 0; all stored operands = 0.
  - Reset mid-stall or mid-flush also clears everything; reset overrides all.
- Register update priority per clock edge:
  - rst_i: clear.
  - stall_i: hold every stored field.
  - flush_i: valid=0, regwrite/mem_read/mem_write=0.
  - load_use_stall_o: insert bubble (same effect as flush).
  - Otherwise: capture ID fields; valid=id_valid_i.
- flush_i coincident with stall_i is not applied; the branch unit holds flush_i until stall_i drops.
- Load-use hazard (combinational):
  - load_use_stall_o = ex_valid & ex_mem_read & ex_rd≠0 & id_valid_i & (ex_rd==rs1 used | ex_rd==rs2 used).
  - rs1 is used by OP, OP-IMM, LOAD, STORE, BRANCH, JALR.
  - rs2 is used by OP, STORE, BRANCH.
  - Deasserts the cycle after the bubble.
- Forwarding (combinational, on the registered rs1/rs2 values):
  - EX/MEM match has priority over MEM/WB.
  - A match requires regwrite=1 and rd≠0 and rd==rs.
  - Otherwise the registered file value is used.
- Operand select:
  - OP, BRANCH: rs1 / rs2.
  - OP-IMM, LOAD, STORE: rs1 / imm.
  - LUI: 0 / imm.
  - AUIPC: pc / imm.
  - JAL, JALR: pc / LINK_OFFSET.
- ALU opcode = {funct3, b1, b0}:
  - b1 = funct7[5] for OP; imm[10] for OP-IMM with funct3=101; 0 otherwise.
  - b0 = funct7[0] for OP only.
  - Non-OP/OP-IMM classes use 00000, except BRANCH, which uses 00010 (SUB).
- Unknown opcode: captured with regwrite/mem_read/mem_write = 0.
- Latency: ID inputs appear on the EX outputs one cycle after capture.

Decomposition:
- rv32_pkg holds:
  - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR);
  - ALU opcode constants (ADD..REMU);
  - field slice positions.
- One sub-module, ex_forward_mux: combinational rs1/rs2 forwarding selection. Instantiated twice.

Test Plan:
- ADD x3,x1,x2 with rs1=5, rs2=7, no hazards -> next cycle alu1=5, alu2=7, alu_op=00000, ex_rd=3, ex_valid=1.
- exmem rd=1 result 0x10 and memwb rd=1 data 0x20, EX holds rs1=x1 -> alu1=0x10. With exmem_regwrite=0 -> alu1=0x20. With exmem_rd=0, regwrite=1 -> no forward.
- LW x5 in EX, ID holds ADD x6,x5,x1 -> load_use_stall_o=1; next cycle ex_valid=0; ADD enters the cycle after with load_use_stall_o=0.
- stall_i high 3 cycles with new ID data -> all outputs frozen. flush_i with stall_i=0 -> ex_valid=0, ex_regwrite=0 next cycle.
- SRAI x2,x1,3 -> alu_op=10110, alu2=3. ADDI x2,x1,0x400 -> alu_op=00000. DIV -> 10001. REMU -> 11101.
- rst_i asserted during a load-use bubble -> next cycle all outputs 0; AUIPC at pc=0x100, imm=0x1000 afterwards -> alu1=0x100, alu2=0x1000.
